// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC alarm controller: FSM states, BCD field limits
// and the widths of the ring and page tick counters.
package rtc_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StSetTime  = 2'd1,
    StSetAlarm = 2'd2,
    StRing     = 2'd3
  } rtc_state_e;

  localparam int unsigned HourMax   = 23;
  localparam int unsigned MinSecMax = 59;

  localparam int unsigned RingCntW = 8;
  localparam int unsigned PageCntW = 8;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter: counts 00..MaxVal with synchronous clear, wrap and carry-out.
// Also exposes its next value so the parent can look one tick ahead.
module bcd_mod_counter #(
  parameter int unsigned MaxVal = 59
) (
  input  logic       clk_in_1Hz,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clear,
  output logic [3:0] q_high,
  output logic [3:0] q_lower,
  output logic [3:0] nxt_high,
  output logic [3:0] nxt_lower,
  output logic       carry
);

  localparam logic [3:0] MaxHigh  = 4'(MaxVal / 10);
  localparam logic [3:0] MaxLower = 4'(MaxVal % 10);

  logic [3:0] high_q, high_d;
  logic [3:0] lower_q, lower_d;
  logic       at_max;

  always_comb begin
    at_max  = (high_q == MaxHigh) && (lower_q == MaxLower);
    carry   = inc && !clear && at_max;
    high_d  = high_q;
    lower_d = lower_q;
    if (clear || (inc && at_max)) begin
      high_d  = 4'd0;
      lower_d = 4'd0;
    end else if (inc) begin
      if (lower_q == 4'd9) begin
        high_d  = high_q + 4'd1;
        lower_d = 4'd0;
      end else begin
        lower_d = lower_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_in_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      high_q  <= 4'd0;
      lower_q <= 4'd0;
    end else begin
      high_q  <= high_d;
      lower_q <= lower_d;
    end
  end

  assign q_high    = high_q;
  assign q_lower   = lower_q;
  assign nxt_high  = high_d;
  assign nxt_lower = lower_d;

endmodule

// File: rtl/rtc_alarm_ctrl.sv
// Alarm clock controller on a 1 Hz tick: BCD time and alarm, set modes, alarm ringing.
// Optional macro RTC_AUTO_PAGE_EN adds automatic time/alarm display paging in RUN.
module rtc_alarm_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned ALARM_RING_SEC = 30,
  parameter int unsigned PAGE_HOLD_SEC  = 5
) (
  input  logic       clk_in_1Hz,
  input  logic       rst_n,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       alarm_ack,
  output logic [3:0] time_hour_high,
  output logic [3:0] time_hour_lower,
  output logic [3:0] time_min_high,
  output logic [3:0] time_min_lower,
  output logic [3:0] time_sec_high,
  output logic [3:0] time_sec_lower,
  output logic [3:0] warningtime_hour_high,
  output logic [3:0] warningtime_hour_lower,
  output logic [3:0] warningtime_min_high,
  output logic [3:0] warningtime_min_lower,
  output logic       time_set,
  output logic       disp_alarm,
  output logic       flash_bit,
  output logic       alarm_out
);

  localparam logic [RingCntW-1:0] RingLast = RingCntW'(ALARM_RING_SEC - 1);

  rtc_state_e state_q, state_d;
  logic [RingCntW-1:0] ring_cnt_q, ring_cnt_d;
  logic ring_done;
  logic flash_q;
  logic page_show;

  // set_time alone decides whether the next state is SET_TIME, so it selects the time mode.
  logic sec_inc, sec_clear, sec_carry, min_inc, min_carry, hour_inc;
  logic alarm_edit, match;
  logic [3:0] sec_nxt_high, sec_nxt_lower, min_nxt_high, min_nxt_lower;
  logic [3:0] hour_nxt_high, hour_nxt_lower;
  logic unused_hour_carry, unused_alarm_hour_carry, unused_alarm_min_carry;
  logic [3:0] unused_ah_nxt_high, unused_ah_nxt_lower, unused_am_nxt_high, unused_am_nxt_lower;

  assign sec_inc   = !set_time;
  assign sec_clear = set_time;
  assign min_inc   = set_time ? inc_min : sec_carry;
  assign hour_inc  = set_time ? inc_hr : min_carry;

  assign alarm_edit = !set_time && set_alarm && ((state_q == StRun) || (state_q == StSetAlarm));

  // Match looks at the value the time counters load on this edge.
  assign match = alarm_en
              && ({sec_nxt_high, sec_nxt_lower} == 8'h00)
              && ({min_nxt_high, min_nxt_lower}
                  == {warningtime_min_high, warningtime_min_lower})
              && ({hour_nxt_high, hour_nxt_lower}
                  == {warningtime_hour_high, warningtime_hour_lower});

  bcd_mod_counter #(.MaxVal(MinSecMax)) u_sec (
    .clk_in_1Hz (clk_in_1Hz),
    .rst_n      (rst_n),
    .inc        (sec_inc),
    .clear      (sec_clear),
    .q_high     (time_sec_high),
    .q_lower    (time_sec_lower),
    .nxt_high   (sec_nxt_high),
    .nxt_lower  (sec_nxt_lower),
    .carry      (sec_carry)
  );

  bcd_mod_counter #(.MaxVal(MinSecMax)) u_min (
    .clk_in_1Hz (clk_in_1Hz),
    .rst_n      (rst_n),
    .inc        (min_inc),
    .clear      (1'b0),
    .q_high     (time_min_high),
    .q_lower    (time_min_lower),
    .nxt_high   (min_nxt_high),
    .nxt_lower  (min_nxt_lower),
    .carry      (min_carry)
  );

  bcd_mod_counter #(.MaxVal(HourMax)) u_hour (
    .clk_in_1Hz (clk_in_1Hz),
    .rst_n      (rst_n),
    .inc        (hour_inc),
    .clear      (1'b0),
    .q_high     (time_hour_high),
    .q_lower    (time_hour_lower),
    .nxt_high   (hour_nxt_high),
    .nxt_lower  (hour_nxt_lower),
    .carry      (unused_hour_carry)
  );

  bcd_mod_counter #(.MaxVal(MinSecMax)) u_alarm_min (
    .clk_in_1Hz (clk_in_1Hz),
    .rst_n      (rst_n),
    .inc        (alarm_edit && inc_min),
    .clear      (1'b0),
    .q_high     (warningtime_min_high),
    .q_lower    (warningtime_min_lower),
    .nxt_high   (unused_am_nxt_high),
    .nxt_lower  (unused_am_nxt_lower),
    .carry      (unused_alarm_min_carry)
  );

  bcd_mod_counter #(.MaxVal(HourMax)) u_alarm_hour (
    .clk_in_1Hz (clk_in_1Hz),
    .rst_n      (rst_n),
    .inc        (alarm_edit && inc_hr),
    .clear      (1'b0),
    .q_high     (warningtime_hour_high),
    .q_lower    (warningtime_hour_lower),
    .nxt_high   (unused_ah_nxt_high),
    .nxt_lower  (unused_ah_nxt_lower),
    .carry      (unused_alarm_hour_carry)
  );

  always_ff @(posedge clk_in_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (set_time)       state_d = StSetTime;
        else if (set_alarm) state_d = StSetAlarm;
        else if (match)     state_d = StRing;
      end
      StSetTime: begin
        if (!set_time) state_d = StRun;
      end
      StSetAlarm: begin
        if (set_time)        state_d = StSetTime;
        else if (!set_alarm) state_d = StRun;
      end
      StRing: begin
        if (set_time)                                 state_d = StSetTime;
        else if (alarm_ack || !alarm_en || ring_done) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    time_set   = 1'b0;
    disp_alarm = 1'b0;
    alarm_out  = 1'b0;
    unique case (state_q)
      StRun:      disp_alarm = page_show;
      StSetTime:  time_set   = 1'b1;
      StSetAlarm: begin
        time_set   = 1'b1;
        disp_alarm = 1'b1;
      end
      StRing:     alarm_out  = 1'b1;
      default:    ;
    endcase
  end

  assign ring_done = (ring_cnt_q == RingLast);

  always_comb begin
    ring_cnt_d = '0;
    if ((state_q == StRing) && (state_d == StRing)) begin
      ring_cnt_d = ring_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      ring_cnt_q <= '0;
      flash_q    <= 1'b0;
    end else begin
      ring_cnt_q <= ring_cnt_d;
      flash_q    <= ~flash_q;
    end
  end

  assign flash_bit = flash_q;

`ifdef RTC_AUTO_PAGE_EN
  localparam logic [PageCntW-1:0] PageLast = PageCntW'(PAGE_HOLD_SEC - 1);

  logic [PageCntW-1:0] page_cnt_q, page_cnt_d;
  logic page_q, page_d;

  // Paging restarts from the time page whenever RUN is (re)entered or the alarm is disarmed.
  always_comb begin
    page_cnt_d = page_cnt_q;
    page_d     = page_q;
    if ((state_d != StRun) || !alarm_en) begin
      page_cnt_d = '0;
      page_d     = 1'b0;
    end else if (page_cnt_q == PageLast) begin
      page_cnt_d = '0;
      page_d     = ~page_q;
    end else begin
      page_cnt_d = page_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      page_cnt_q <= '0;
      page_q     <= 1'b0;
    end else begin
      page_cnt_q <= page_cnt_d;
      page_q     <= page_d;
    end
  end

  assign page_show = page_q;
`else
  logic unused_page_hold;
  assign unused_page_hold = ^PAGE_HOLD_SEC;
  assign page_show        = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_alarm_ctrl.sv
// Self-checking bench for rtc_alarm_ctrl: directed sequences, a vector table and random
// stimulus, all compared against a seconds-of-day reference model.
module tb_rtc_alarm_ctrl;

  localparam int unsigned RingSec = 30;
  localparam int unsigned PageSec = 5;
  localparam int          DaySec  = 86400;

  logic clk_in_1Hz = 1'b0;
  logic rst_n      = 1'b0;
  logic set_time   = 1'b0;
  logic set_alarm  = 1'b0;
  logic inc_hr     = 1'b0;
  logic inc_min    = 1'b0;
  logic alarm_en   = 1'b0;
  logic alarm_ack  = 1'b0;
  logic [3:0] time_hour_high, time_hour_lower, time_min_high, time_min_lower;
  logic [3:0] time_sec_high, time_sec_lower;
  logic [3:0] warningtime_hour_high, warningtime_hour_lower;
  logic [3:0] warningtime_min_high, warningtime_min_lower;
  logic time_set, disp_alarm, flash_bit, alarm_out;

  always #5 clk_in_1Hz = ~clk_in_1Hz;

  rtc_alarm_ctrl #(
    .ALARM_RING_SEC (RingSec),
    .PAGE_HOLD_SEC  (PageSec)
  ) dut (
    .clk_in_1Hz             (clk_in_1Hz),
    .rst_n                  (rst_n),
    .set_time               (set_time),
    .set_alarm              (set_alarm),
    .inc_hr                 (inc_hr),
    .inc_min                (inc_min),
    .alarm_en               (alarm_en),
    .alarm_ack              (alarm_ack),
    .time_hour_high         (time_hour_high),
    .time_hour_lower        (time_hour_lower),
    .time_min_high          (time_min_high),
    .time_min_lower         (time_min_lower),
    .time_sec_high          (time_sec_high),
    .time_sec_lower         (time_sec_lower),
    .warningtime_hour_high  (warningtime_hour_high),
    .warningtime_hour_lower (warningtime_hour_lower),
    .warningtime_min_high   (warningtime_min_high),
    .warningtime_min_lower  (warningtime_min_lower),
    .time_set               (time_set),
    .disp_alarm             (disp_alarm),
    .flash_bit              (flash_bit),
    .alarm_out              (alarm_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time as seconds of day, alarm as minutes of day.
  typedef enum int {MRun, MSetTime, MSetAlarm, MRing} mode_e;
  mode_e m_mode;
  int    m_tod, m_alarm_min, m_edge, m_ring_start, m_page_since;
  bit    m_flash, m_page;

  typedef struct {
    bit st, sa, ih, im;
    int hh, mm, ss, ahh, amm;
    bit ts, disp;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int two(input logic [3:0] hi, input logic [3:0] lo);
    return int'(hi) * 10 + int'(lo);
  endfunction

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, "_hour"}, two(time_hour_high, time_hour_lower), h);
    chk({name, "_min"}, two(time_min_high, time_min_lower), m);
    chk({name, "_sec"}, two(time_sec_high, time_sec_lower), s);
  endtask

  task automatic model_reset();
    m_mode       = MRun;
    m_tod        = 0;
    m_alarm_min  = 0;
    m_edge       = 0;
    m_ring_start = 0;
    m_page_since = 0;
    m_flash      = 1'b0;
    m_page       = 1'b0;
  endtask

  task automatic model_step();
    int    nxt, h, mi;
    mode_e nm;
    m_edge++;
    nxt = (m_tod + 1) % DaySec;
    nm  = m_mode;
    case (m_mode)
      MRun: begin
        if (set_time) nm = MSetTime;
        else if (set_alarm) nm = MSetAlarm;
        else if (alarm_en && nxt == m_alarm_min * 60) begin
          nm           = MRing;
          m_ring_start = m_edge;
        end
      end
      MSetTime:  if (!set_time) nm = MRun;
      MSetAlarm: begin
        if (set_time) nm = MSetTime;
        else if (!set_alarm) nm = MRun;
      end
      MRing: begin
        if (set_time) nm = MSetTime;
        else if (alarm_ack || !alarm_en || (m_edge - m_ring_start >= int'(RingSec))) nm = MRun;
      end
      default: nm = MRun;
    endcase
    if (set_time) begin
      h     = (m_tod / 3600 + int'(inc_hr)) % 24;
      mi    = ((m_tod / 60) % 60 + int'(inc_min)) % 60;
      m_tod = h * 3600 + mi * 60;
    end else begin
      m_tod = nxt;
    end
    if (nm == MSetAlarm) begin
      h           = (m_alarm_min / 60 + int'(inc_hr)) % 24;
      mi          = (m_alarm_min % 60 + int'(inc_min)) % 60;
      m_alarm_min = h * 60 + mi;
    end
    m_flash = !m_flash;
`ifdef RTC_AUTO_PAGE_EN
    if (nm != MRun || !alarm_en) begin
      m_page       = 1'b0;
      m_page_since = m_edge;
    end else if ((m_edge - m_page_since) % int'(PageSec) == 0) begin
      m_page = !m_page;
    end
`endif
    m_mode = nm;
  endtask

  task automatic check_all();
    int h, mi, s, ah, am;
    h  = m_tod / 3600;
    mi = (m_tod / 60) % 60;
    s  = m_tod % 60;
    ah = m_alarm_min / 60;
    am = m_alarm_min % 60;
    chk("time_hour_high", int'(time_hour_high), h / 10);
    chk("time_hour_lower", int'(time_hour_lower), h % 10);
    chk("time_min_high", int'(time_min_high), mi / 10);
    chk("time_min_lower", int'(time_min_lower), mi % 10);
    chk("time_sec_high", int'(time_sec_high), s / 10);
    chk("time_sec_lower", int'(time_sec_lower), s % 10);
    chk("alarm_hour_high", int'(warningtime_hour_high), ah / 10);
    chk("alarm_hour_lower", int'(warningtime_hour_lower), ah % 10);
    chk("alarm_min_high", int'(warningtime_min_high), am / 10);
    chk("alarm_min_lower", int'(warningtime_min_lower), am % 10);
    chk("time_set", int'(time_set), int'(m_mode == MSetTime || m_mode == MSetAlarm));
    chk("disp_alarm", int'(disp_alarm),
        int'(m_mode == MSetAlarm || (m_mode == MRun && m_page)));
    chk("flash_bit", int'(flash_bit), int'(m_flash));
    chk("alarm_out", int'(alarm_out), int'(m_mode == MRing));
  endtask

  task automatic set_inputs(input bit st, input bit sa, input bit ih, input bit im,
                            input bit en, input bit ack);
    set_time  = st;
    set_alarm = sa;
    inc_hr    = ih;
    inc_min   = im;
    alarm_en  = en;
    alarm_ack = ack;
  endtask

  task automatic tick();
    @(posedge clk_in_1Hz);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset is held across one clock edge, then released away from any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk_in_1Hz);
    #1;
    check_all();
    @(negedge clk_in_1Hz);
    rst_n = 1'b1;
  endtask

  task automatic edit(input bit alarm, input int dh, input int dm, input bit en);
    int n;
    n = (dh > dm) ? dh : dm;
    for (int i = 0; i < n; i++) begin
      set_inputs(!alarm, alarm, i < dh, i < dm, en, 0);
      tick();
    end
  endtask

  // From reset: alarm 00:01 armed, ends on the edge where ringing starts at 00:01:00.
  task automatic ring_setup();
    do_reset();
    set_inputs(0, 1, 0, 1, 1, 0);
    tick();
    set_inputs(0, 0, 0, 0, 1, 0);
    run(59);
    chk("ring_start_alarm_out", int'(alarm_out), 1);
    chk_time("ring_start", 0, 1, 0);
  endtask

  initial begin
    vec_t vecs[5];
    int   ring_len;

    vecs[0] = '{1, 1, 1, 1, 10, 0, 0, 0, 0, 1, 0};
    vecs[1] = '{0, 1, 0, 0, 10, 0, 1, 0, 0, 0, 0};
    vecs[2] = '{0, 1, 1, 1, 10, 0, 2, 1, 1, 1, 1};
    vecs[3] = '{1, 1, 0, 1, 10, 1, 0, 1, 1, 1, 0};
    vecs[4] = '{0, 0, 0, 0, 10, 1, 1, 1, 1, 0, 0};

    do_reset();
    chk_time("reset", 0, 0, 0);
    chk("reset_alarm_out", int'(alarm_out), 0);

    // Hour set for 25 ticks wraps 00 -> 01 with seconds held at 00.
    set_inputs(1, 0, 1, 0, 0, 0);
    run(25);
    chk_time("set_hr25", 1, 0, 0);
    chk("set_hr25_time_set", int'(time_set), 1);

    // Both set requests: set_time wins; then joint increments at 09:59 with no hour carry.
    do_reset();
    set_inputs(1, 1, 0, 0, 0, 0);
    tick();
    chk("both_set_time_set", int'(time_set), 1);
    chk("both_set_disp_alarm", int'(disp_alarm), 0);
    edit(0, 9, 59, 0);
    chk_time("set_0959", 9, 59, 0);
    foreach (vecs[i]) begin
      set_inputs(vecs[i].st, vecs[i].sa, vecs[i].ih, vecs[i].im, 0, 0);
      tick();
      chk_time($sformatf("vec%0d", i), vecs[i].hh, vecs[i].mm, vecs[i].ss);
      chk($sformatf("vec%0d_alarm_hour", i),
          two(warningtime_hour_high, warningtime_hour_lower), vecs[i].ahh);
      chk($sformatf("vec%0d_alarm_min", i),
          two(warningtime_min_high, warningtime_min_lower), vecs[i].amm);
      chk($sformatf("vec%0d_time_set", i), int'(time_set), int'(vecs[i].ts));
      chk($sformatf("vec%0d_disp_alarm", i), int'(disp_alarm), int'(vecs[i].disp));
    end

    // Day wrap 23:59:58 -> 00:00:00.
    do_reset();
    edit(0, 23, 59, 0);
    set_inputs(0, 0, 0, 0, 0, 0);
    tick();
    run(57);
    chk_time("pre_wrap", 23, 59, 58);
    tick();
    chk_time("wrap_59", 23, 59, 59);
    tick();
    chk_time("wrap_00", 0, 0, 0);

    // Alarm 07:30 rings at the 07:30:00 edge for RingSec ticks without ack.
    do_reset();
    edit(1, 7, 30, 0);
    edit(0, 7, 29, 0);
    set_inputs(0, 0, 0, 0, 1, 0);
    tick();
    run(57);
    chk_time("pre_alarm", 7, 29, 58);
    tick();
    chk("pre_alarm_out", int'(alarm_out), 0);
    tick();
    chk_time("alarm_rise", 7, 30, 0);
    chk("alarm_rise_out", int'(alarm_out), 1);
    ring_len = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!alarm_out) break;
      ring_len++;
    end
    chk("ring_len", ring_len, int'(RingSec));

    // Ack at ring tick 3 stops ringing on the next edge; time keeps counting.
    ring_setup();
    run(3);
    set_inputs(0, 0, 0, 0, 1, 1);
    tick();
    chk("ack_alarm_out", int'(alarm_out), 0);
    chk_time("ack", 0, 1, 4);
    set_inputs(0, 0, 0, 0, 1, 0);
    tick();
    chk("ack_no_rematch", int'(alarm_out), 0);

    // set_time during ringing goes straight to SET_TIME.
    ring_setup();
    set_inputs(1, 0, 0, 0, 1, 0);
    tick();
    chk("ring_set_alarm_out", int'(alarm_out), 0);
    chk("ring_set_time_set", int'(time_set), 1);
    chk_time("ring_set", 0, 1, 0);

    // Display paging with the alarm armed in RUN.
    do_reset();
    set_inputs(0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
`ifdef RTC_AUTO_PAGE_EN
      chk($sformatf("page_tick%0d", k), int'(disp_alarm), (k / 5) % 2);
`else
      chk($sformatf("page_off_tick%0d", k), int'(disp_alarm), 0);
`endif
    end

    // Asynchronous reset while ringing clears everything without waiting for an edge.
    ring_setup();
    run(2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("midring_alarm_out", int'(alarm_out), 0);
    chk_time("midring", 0, 0, 0);
    do_reset();

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      set_inputs($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_alarm_ctrl.md
RTC_ALARM_CTRL -- requirements
Module: rtc_alarm_ctrl

Interface
REQ-001 SHALL have parameter ALARM_RING_SEC, default 30: the number of ticks alarm_out stays high if it is not acknowledged.
REQ-002 SHALL have parameter PAGE_HOLD_SEC, default 5: the number of ticks per display page in auto-page mode.
REQ-003 SHALL use reset rst_n, asynchronous, active-low, and clock clk_in_1Hz.
REQ-004 SHALL have the following ports:
- clk_in_1Hz  in  1  1 Hz tick clock.
- rst_n  in  1  async active-low reset.
- set_time  in  1  level; request time-set mode.
- set_alarm  in  1  level; request alarm-set mode.
- inc_hr  in  1  level; increment the selected hour field each tick.
- inc_min  in  1  level; increment the selected minute field each tick.
- alarm_en  in  1  level; arm alarm matching.
- alarm_ack  in  1  level; stop ringing.
- time_hour_high, time_hour_lower, time_min_high, time_min_lower, time_sec_high, time_sec_lower  out  4 each  BCD time digits.
- warningtime_hour_high, warningtime_hour_lower, warningtime_min_high, warningtime_min_lower  out  4 each  BCD alarm digits.
- time_set  out  1  high in either set mode; the display blinks separators.
- disp_alarm  out  1  display page select: 0 = time page, 1 = alarm page.
- flash_bit  out  1  blink phase.
- alarm_out  out  1  high while ringing.

Function
REQ-005 SHALL implement FSM states RUN, SET_TIME, SET_ALARM and RING; all transitions occur on a clk_in_1Hz rising edge.
REQ-006 SHALL apply these transitions in RUN: set_time=1 goes to SET_TIME; else set_alarm=1 goes to SET_ALARM; else an alarm match goes to RING. set_time has priority over set_alarm.
REQ-007 SHALL, in SET_TIME:
- clear seconds to 00 on entry and hold them there;
- with inc_hr, increment hour mod 24;
- with inc_min, increment minute mod 60 with no carry into hour;
- apply both increments in the same tick when both are high;
- return to RUN when set_time=0.
REQ-008 SHALL, in SET_ALARM, apply the same increment rules to the alarm hour and minute while time keeps counting, and return to RUN when set_alarm=0; set_time=1 goes directly to SET_TIME.
REQ-009 SHALL count time in RUN, SET_ALARM and RING as BCD hh:mm:ss; 23:59:59 wraps to 00:00:00, 59 s carries into minutes and 59 min carries into hours.
REQ-010 SHALL detect a match when alarm_en=1 and the next time value equals alarm hh:mm:00; alarm_out then rises on the same edge at which the time display shows hh:mm:00.
REQ-011 SHALL, in RING, hold alarm_out=1 and go to RUN on whichever comes first: alarm_ack=1, alarm_en=0, or ALARM_RING_SEC ticks elapsed.
REQ-012 SHALL, when set_time=1 during RING, go to SET_TIME and drop alarm_out on that edge; a match is never re-detected while in RING.
REQ-013 SHALL drive time_set=1 exactly in SET_TIME and SET_ALARM.
REQ-014 SHALL drive disp_alarm=1 in SET_ALARM and 0 in SET_TIME and RING; its RUN value is given under Configuration.
REQ-015 SHALL toggle flash_bit every tick in all states.
REQ-016 SHALL produce every digit output directly from a register, with no combinational path from any input.

Reset
REQ-017 SHALL, while rst_n=0, set:
- state = RUN;
- time = 00:00:00;
- alarm = 00:00;
- time_set, disp_alarm, flash_bit and alarm_out = 0;
- ring and page counters = 0.
REQ-018 SHALL, when reset is asserted mid-RING or mid-set, abort immediately and ignore all inputs until the first edge after release.

Configuration
REQ-019 SHALL, with macro RTC_AUTO_PAGE_EN defined, toggle disp_alarm in RUN every PAGE_HOLD_SEC ticks when alarm_en=1, and force it to 0 with the page counter cleared when alarm_en=0. On return from SET_ALARM the page counter restarts with disp_alarm=0.
REQ-020 SHALL, without RTC_AUTO_PAGE_EN, hold disp_alarm=0 in RUN and omit the page counter.

Structure
REQ-021 SHALL place the state enumeration, BCD limit constants (hour 23, minute/second 59) and ring/page counter widths in the shared package rtc_pkg.
REQ-022 SHALL instantiate sub-module bcd_mod_counter, a two-digit BCD modulo counter with inc, clear and carry-out, three times for time and twice for alarm.

Verification
REQ-023 SHALL cover: reset, set_time=1 and inc_hr=1 for 25 ticks -> hour 01, seconds 00, time_set=1.
REQ-024 SHALL cover: time 23:59:58 in RUN for 2 ticks -> 00:00:00, with no carry glitch into hour 24.
REQ-025 SHALL cover: alarm 07:30, alarm_en=1, time 07:29:58 -> alarm_out rises at the edge showing 07:30:00 and falls 30 ticks later with no ack.
REQ-026 SHALL cover: ringing with alarm_ack=1 at tick 3 -> alarm_out=0 on the next edge, state RUN, time still counting.
REQ-027 SHALL cover: set_time and set_alarm both 1 from RUN -> SET_TIME, disp_alarm=0; then inc_hr and inc_min together at 09:59 -> 10:00, with minute wrap and no hour carry.
REQ-028 SHALL cover: with RTC_AUTO_PAGE_EN and alarm_en=1 in RUN -> disp_alarm toggles at ticks 5, 10, 15; rst_n pulse mid-ring -> all outputs 0 and time 00:00:00.
